// File: rtl/cdc_pkg.sv
// Shared definitions for the source-side CDC transfer controller.
package cdc_pkg;

    // Handshake FSM states; encoding is fixed so state can be probed directly.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_RELEASE = 2'b10
    } cdc_state_e;

    // Default depth of the acknowledge synchronizer.
    localparam int DEFAULT_STAGE_COUNT = 2;

    // Ceiling log2, usable in constant expressions for index widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/bus_synchronizer.sv
// Multi-flop synchronizer bringing a bus into the clk domain.
// Only safe for single-bit or otherwise glitch-free (Gray / level) inputs.
module bus_synchronizer #(
    parameter int BUS_WIDTH   = 1,
    parameter int STAGE_COUNT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] asynchronous_data,
    output logic [BUS_WIDTH-1:0] synchronous_data
);

    logic [STAGE_COUNT-1:0][BUS_WIDTH-1:0] r_sync;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGE_COUNT-2:0], asynchronous_data};
        end
    end

    assign synchronous_data = r_sync[STAGE_COUNT-1];

endmodule

// File: rtl/cdc_transfer_arbiter.sv
// Source-domain controller sharing one data crossing among NUM_REQ
// requesters: round-robin arbitration, then a 4-phase level req/ack
// handshake with the payload held stable until the completion grant.
module cdc_transfer_arbiter
    import cdc_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int STAGE_COUNT = DEFAULT_STAGE_COUNT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           request,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] request_data,
    input  logic                         asynchronous_ack,
    output logic                         transfer_valid,
    output logic [BUS_WIDTH-1:0]         transfer_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [clog2(NUM_REQ)-1:0]    grant_index,
    output logic                         busy
);

    localparam int IDX_W = clog2(NUM_REQ);

    cdc_state_e            r_state;
    cdc_state_e            w_state_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic [BUS_WIDTH-1:0]  r_data;
    logic [BUS_WIDTH-1:0]  w_data_nxt;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    w_grant_nxt;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_owner_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      w_ptr_nxt;

    logic                  w_ack_sync;
    logic                  w_any;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [BUS_WIDTH-1:0]  w_sel_data;

    // Acknowledge from the destination domain, brought into clk.
    bus_synchronizer #(
        .BUS_WIDTH   (1),
        .STAGE_COUNT (STAGE_COUNT)
    ) u_ack_sync (
        .clk               (clk),
        .reset             (reset),
        .asynchronous_data (asynchronous_ack),
        .synchronous_data  (w_ack_sync)
    );

    // Round-robin pick: first set request at or above the pointer, wrapping.
    always_comb begin
        w_any      = 1'b0;
        w_sel_idx  = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            cand = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_any && request[cand]) begin
                w_any      = 1'b1;
                w_sel_idx  = IDX_W'(cand);
                w_sel_data = request_data[cand*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Next state and next register values for the handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_data_nxt  = w_sel_data;
                    w_owner_nxt = w_sel_idx;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Payload stays put; only the req level drops once acked.
                if (w_ack_sync) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Ack must return low before the transfer counts as done.
                if (!w_ack_sync) begin
                    w_grant_nxt[r_owner] = 1'b1;
                    w_ptr_nxt = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    assign transfer_valid = r_valid;
    assign transfer_data  = r_data;
    assign grant          = r_grant;
    assign grant_index    = r_owner;
    // The grant cycle is already back in IDLE but still belongs to the transfer.
    assign busy           = (r_state != ST_IDLE) || (|r_grant);

endmodule
